// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values and controller phase encoding.
// Used by the sequencer, ALU and instruction decoder.
`timescale 1ns/1ps
package cpu_pkg;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Instructions whose result is written back into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer with a sticky halted state; all control
// strobes are decoded combinationally from the registered phase.
//
//   state      | meaning
//   INST_ADDR  | PC drives the address bus
//   INST_FETCH | read instruction word
//   INST_LOAD  | load instruction register
//   IDLE       | hold instruction register load
//   OP_ADDR    | bump PC, enter HALTED on HLT
//   OP_FETCH   | read operand for ALU-class ops
//   ALU_OP     | SKZ skip, JMP load, STO drive bus
//   STORE      | accumulator load / memory write / jump
//   HALTED     | parked until reset (phase reads OP_ADDR)
`timescale 1ns/1ps
module seq_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    aluop    = is_aluop(opcode);
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;

    if (halted_q) begin
      halt = 1'b1;
    end else begin
      if (phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end

      case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = (opcode == OP_JMP);
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  // The halted state is reported as the phase it was entered from.
  assign phase = halted_q ? OP_ADDR : phase_q;

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
- REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
- REQ-003 SHALL have port opcode, input, 3 bits: instruction-register opcode field (HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111).
- REQ-004 SHALL have port zero, input, 1 bit: accumulator-is-zero flag.
- REQ-005 SHALL have port sel, output, 1 bit: address mux select (1=PC, 0=IR operand).
- REQ-006 SHALL have port rd, output, 1 bit: memory read enable.
- REQ-007 SHALL have port ld_ir, output, 1 bit: instruction-register load.
- REQ-008 SHALL have port inc_pc, output, 1 bit: program-counter increment.
- REQ-009 SHALL have port ld_pc, output, 1 bit: program-counter load.
- REQ-010 SHALL have port ld_ac, output, 1 bit: accumulator load strobe to acc_reg.
- REQ-011 SHALL have port wr, output, 1 bit: memory write enable.
- REQ-012 SHALL have port data_e, output, 1 bit: accumulator-to-bus driver enable.
- REQ-013 SHALL have port halt, output, 1 bit: CPU halted.
- REQ-014 SHALL have port phase, output, 3 bits: current state encoding, for debug.

Function
- REQ-015 SHALL implement phases INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), plus a HALTED state.
- REQ-016 SHALL advance 0->1->...->7->0, one phase per clock.
- REQ-017 SHALL go OP_ADDR->HALTED instead of OP_FETCH when opcode==HLT.
- REQ-018 SHALL leave HALTED only on reset.
- REQ-019 SHALL drive all outputs combinationally from the registered phase, opcode and zero (Moore per phase, zero-cycle decode).
- REQ-020 Term ALUOP = opcode in {ADD, AND, XOR, LDA}.
- REQ-021 INST_ADDR SHALL drive sel=1.
- REQ-022 INST_FETCH SHALL drive sel=1 and rd=1.
- REQ-023 INST_LOAD and IDLE SHALL drive sel=1, rd=1 and ld_ir=1.
- REQ-024 OP_ADDR SHALL drive inc_pc=1 and halt=(opcode==HLT).
- REQ-025 OP_FETCH SHALL drive rd=ALUOP.
- REQ-026 ALU_OP SHALL drive rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP) and data_e=(opcode==STO).
- REQ-027 STORE SHALL drive rd=ALUOP, ld_ac=ALUOP, inc_pc=(opcode==JMP), ld_pc=(opcode==JMP), wr=(opcode==STO) and data_e=(opcode==STO).
- REQ-028 Any output not listed for a phase SHALL be 0.
- REQ-029 HALTED SHALL drive halt=1 and every other output 0; phase SHALL read 4.
- REQ-030 ld_ac SHALL be high for exactly one cycle per ALU-class instruction and never for SKZ, STO, JMP or HLT.
- REQ-031 zero SHALL be sampled only in ALU_OP; changes in other phases SHALL have no effect.
- REQ-032 Opcode changes outside INST_LOAD/IDLE SHALL be decoded as-is, with no internal latching.

Reset
- REQ-033 rst low SHALL force phase to INST_ADDR immediately, independent of clk.
- REQ-034 During reset, outputs SHALL be sel=1 and all others 0, including halt.
- REQ-035 Reset asserted mid-instruction (e.g. during STORE) SHALL abort the instruction with no further ld_ac/wr pulse.
- REQ-036 After rst rises, the first rising edge SHALL move to INST_FETCH.

Structure
- REQ-037 Opcode constants and the phase encoding SHALL reside in the shared package cpu_pkg, which the ALU and decoder also use.
- REQ-038 SHALL be one module: 3-bit phase register, a halted flag, and a combinational decode; no sub-module.

Verification
- REQ-039 Reset then opcode=LDA, run 8 cycles -> phase 0..7; ld_ac=1 only in phase 7; rd=1 in phases 1,2,3,5,6,7.
- REQ-040 opcode=STO -> data_e=1 in phases 6-7, wr=1 in phase 7 only, ld_ac=0 throughout.
- REQ-041 opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6. zero=0 -> inc_pc=1 in phase 4 only.
- REQ-042 opcode=JMP -> ld_pc=1 in phases 6-7 and inc_pc=1 in phases 4 and 7.
- REQ-043 opcode=HLT -> halt=1 in phase 4, then held for 20 cycles with all other outputs 0. rst low -> halt=0, sel=1.
- REQ-044 opcode=ADD, rst pulsed low 2 ns into STORE -> ld_ac drops immediately and phase=0; next instruction completes normally.
